// File: rtl/mv_mult_stream_if.sv
// Bundle of the coefficient-write, vector-input and result-output signals of mv_mult_stream.
// N and W must match the parameters of the connected mv_mult_stream instance.
// master = upstream/downstream driver side, slave = the multiplier itself.
interface mv_mult_stream_if #(
  parameter int N = 3,
  parameter int W = 4
);
  localparam int AW = $clog2(N * N);
  localparam int OW = 2 * W + $clog2(N);

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/mv_mult_stream.sv
// Sequential N x N matrix-vector multiplier: loads a vector, runs one MAC per cycle, streams N results.
// Latency: first result valid N*N+1 cycles after the last input handshake; one vector per N+N*N+N cycles.
// Backpressure: in_ready only in LOAD; results hold on out_data while out_ready is low.
module mv_mult_stream #(
  parameter int N = 3,
  parameter int W = 4
) (
  input logic          clk,
  input logic          rst,
  mv_mult_stream_if.slave bus
);
  localparam int AW = $clog2(N * N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = 2 * W + $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, row, col, oidx;
  logic [OW-1:0] acc;
  logic [W-1:0]  v   [N];
  logic [W-1:0]  m   [N*N];
  logic [OW-1:0] res [N];

  logic          in_fire, out_fire, mac_last;
  logic [AW-1:0] mac_addr;
  logic [2*W-1:0] prod;
  logic          coef_ok;

  // Handshake qualifiers and the single multiplier for the current (row, col) step
  always_comb begin
    in_fire  = bus.in_valid && (state == S_LOAD);
    out_fire = (state == S_OUTPUT) && bus.out_ready;
    mac_last = (row == LAST) && (col == LAST);
    mac_addr = AW'(int'(row) * N + int'(col));
    prod     = (2*W)'(m[mac_addr]) * (2*W)'(v[col]);
    coef_ok  = bus.coef_we && (state != S_COMPUTE) && (32'(bus.coef_addr) < 32'(N * N));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // FSM next-state: LOAD -> COMPUTE on last element, COMPUTE -> OUTPUT after final MAC, back on out_last handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (in_fire && idx == LAST) state_nxt = S_COMPUTE;
      S_COMPUTE: if (mac_last) state_nxt = S_OUTPUT;
      S_OUTPUT:  if (out_fire && oidx == LAST) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  // FSM outputs; out_data is forced to zero whenever no result is being offered
  always_comb begin
    bus.in_ready  = (state == S_LOAD);
    bus.out_valid = (state == S_OUTPUT);
    bus.out_last  = (state == S_OUTPUT) && (oidx == LAST);
    bus.out_data  = (state == S_OUTPUT) ? res[oidx] : '0;
    bus.busy      = (state != S_LOAD);
  end

  // Datapath: vector capture, row-major MAC sweep, output index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      row  <= '0;
      col  <= '0;
      oidx <= '0;
      acc  <= '0;
      for (int i = 0; i < N; i++) begin
        v[i]   <= '0;
        res[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            v[idx] <= bus.in_data;
            if (idx == LAST) begin
              idx <= '0;
              acc <= '0;
              row <= '0;
              col <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (col == LAST) begin
            res[row] <= acc + OW'(prod);
            acc      <= '0;
            col      <= '0;
            if (row == LAST) begin
              row  <= '0;
              oidx <= '0;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= acc + OW'(prod);
            col <= col + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (out_fire) oidx <= (oidx == LAST) ? '0 : oidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coefficient file: writable outside COMPUTE so a running product sees a frozen matrix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N * N; i++) m[i] <= '0;
    end else if (coef_ok) begin
      m[bus.coef_addr] <= bus.coef_data;
    end
  end
endmodule

// File: tb/tb_mv_mult_stream.sv
// Self-checking bench for mv_mult_stream (N=3, W=4): table-driven vectors plus corner-case sequences.
// Expected results go into a scoreboard queue when a vector is sent and are popped on each output handshake.
module tb_mv_mult_stream;
  localparam int N = 3;
  localparam int W = 4;

  typedef struct packed {
    logic [8:0][3:0] m;
    logic [2:0][3:0] v;
    logic [2:0][9:0] exp;
    logic [3:0]      stall;
  } vec_t;

  typedef struct packed {
    logic [9:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_edge = -1;
  int   mm [9];
  exp_t q [$];
  vec_t tbl [4];

  mv_mult_stream_if #(.N(N), .W(W)) bus ();
  mv_mult_stream #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: a handshake completes on the next rising edge when valid&ready are seen here
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %0d, expected no output", int'(bus.out_data));
        end else begin
          e = q.pop_front();
          chk("out_data", int'(bus.out_data), int'(e.d));
          chk("out_last", int'(bus.out_last), int'(e.l));
          if (bus.out_last) last_edge = cyc + 1;
        end
      end else if (!bus.out_valid) begin
        chk("out_data_idle", int'(bus.out_data), 0);
      end
    end
  end

  task automatic push_exp(input int d, input bit l);
    exp_t e;
    e.d = 10'(d);
    e.l = l;
    q.push_back(e);
  endtask

  task automatic push_model(input logic [2:0][3:0] v);
    int s;
    for (int r = 0; r < 3; r++) begin
      s = 0;
      for (int c = 0; c < 3; c++) s += mm[r*3+c] * int'(v[c]);
      push_exp(s, r == 2);
    end
  endtask

  // One-cycle write; the model only follows writes the design is supposed to accept
  task automatic write_coef(input int addr, input int data, input bit takes);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 4'(data);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    if (takes && addr < 9) mm[addr] = data;
  endtask

  task automatic load_matrix(input logic [8:0][3:0] m);
    for (int i = 0; i < 9; i++) write_coef(i, int'(m[i]), 1'b1);
  endtask

  task automatic send_elem(input logic [3:0] d, input bit wr, input int wa, input int wd);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      chk("busy_while_blocked", int'(bus.busy), 1);
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end else if (n > 0) begin
      chk("accept_after_last", cyc, last_edge);
    end
    if (wr) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(wa);
      bus.coef_data = 4'(wd);
    end
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic send_vec(input logic [2:0][3:0] v, input bit hold, input bit wr, input int wa, input int wd);
    for (int i = 0; i < 3; i++) send_elem(v[i], wr && (i == 2), wa, wd);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [8:0][3:0] m_seq, m_id;
    logic [2:0][3:0] va, vb;
    int cnt;

    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) mm[i] = 0;

    m_id  = {4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    m_seq = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    tbl[0] = '{m: m_id, v: {4'd3, 4'd2, 4'd1}, exp: {10'd3, 10'd2, 10'd1}, stall: 4'd0};
    tbl[1] = '{m: {9{4'd15}}, v: {3{4'd15}}, exp: {3{10'd675}}, stall: 4'd0};
    tbl[2] = '{m: m_seq, v: {4'd2, 4'd0, 4'd1}, exp: {10'd25, 10'd16, 10'd7}, stall: 4'd5};
    tbl[3] = '{m: {4'd1, 4'd1, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd2},
               v: {4'd6, 4'd4, 4'd5}, exp: {10'd15, 10'd12, 10'd10}, stall: 4'd0};

    // Reset values
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Table: latency, consecutive output, optional output stall
    for (int t = 0; t < 4; t++) begin
      load_matrix(tbl[t].m);
      for (int r = 0; r < 3; r++) push_exp(int'(tbl[t].exp[r]), r == 2);
      bus.out_ready = (tbl[t].stall == 0);
      send_vec(tbl[t].v, 1'b0, 1'b0, 0, 0);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus.out_valid && cnt < 50);
      chk("latency", cnt, 10);
      chk("busy_in_output", int'(bus.busy), 1);
      if (tbl[t].stall != 0) begin
        for (int k = 0; k < int'(tbl[t].stall); k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_valid", int'(bus.out_valid), 1);
          chk("stall_hold", int'(bus.out_data), int'(tbl[t].exp[0]));
          chk("stall_last", int'(bus.out_last), 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
        if (j > 0) @(negedge clk);
        chk("out_consecutive", int'(bus.out_valid), 1);
      end
      @(negedge clk);
      chk("out_valid_after_last", int'(bus.out_valid), 0);
      chk("in_ready_after_last", int'(bus.in_ready), 1);
      chk("busy_after_last", int'(bus.busy), 0);
      @(posedge clk); #1;
    end

    // Out-of-range write in LOAD and a write during COMPUTE are both ignored
    load_matrix(m_seq);
    write_coef(9, 15, 1'b0);
    write_coef(15, 15, 1'b0);
    va = {4'd2, 4'd0, 4'd1};
    push_model(va);
    send_vec(va, 1'b0, 1'b0, 0, 0);
    write_coef(0, 9, 1'b0);
    drain();
    push_model(va);
    send_vec(va, 1'b0, 1'b0, 0, 0);
    drain();

    // Coefficient write on the same edge as the final input handshake is used
    load_matrix(m_id);
    mm[8] = 5;
    va = {4'd3, 4'd2, 4'd1};
    push_model(va);
    send_vec(va, 1'b0, 1'b1, 8, 5);
    drain();

    // Back-to-back vectors with in_valid held high
    load_matrix(m_seq);
    va = {4'd2, 4'd0, 4'd1};
    vb = {4'd1, 4'd1, 4'd3};
    push_model(va);
    push_model(vb);
    send_vec(va, 1'b1, 1'b0, 0, 0);
    send_vec(vb, 1'b0, 1'b0, 0, 0);
    drain();

    // Reset in the middle of COMPUTE
    load_matrix(m_seq);
    va = {4'd3, 4'd2, 4'd1};
    send_vec(va, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out_data", int'(bus.out_data), 0);
    chk("abort_out_last", int'(bus.out_last), 0);
    chk("abort_busy", int'(bus.busy), 0);
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 9; i++) mm[i] = 0;
    @(posedge clk); #1;
    push_model(va);
    send_vec(va, 1'b0, 1'b0, 0, 0);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
